// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter in front of a small register bank.
// Ports: clk/rest, req_valid/addr/data/ready per requester, rd_addr/rd_data, grant_id, wr_count.
module reg_bank_arbiter #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rest,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0]  req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic [ID_W-1:0]        grant_id,
  output logic [7:0]             wr_count
);

  logic [WIDTH-1:0]  bank_q [DEPTH];
  logic [WIDTH-1:0]  bank_d [DEPTH];
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [7:0]        wr_count_q, wr_count_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic              found;
  logic [ID_W-1:0]   grant_idx;
  logic              hs;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;

  // (base + off) mod NREQ; NREQ need not be a power of two.
  function automatic logic [ID_W-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NREQ) s = s - NREQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int off = 0; off < NREQ; off++) begin
      if (!found && req_valid[wrap_idx(int'(ptr_q), off)]) begin
        found     = 1'b1;
        grant_idx = wrap_idx(int'(ptr_q), off);
      end
    end
  end

  // No grant may be accepted in a reset cycle.
  assign hs = found & ~rest;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    waddr = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    wdata = req_data[int'(grant_idx)*WIDTH +: WIDTH];
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) bank_d[i] = bank_q[i];
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    wr_count_d = wr_count_q;
    if (hs) begin
      // Out-of-range writes are accepted but dropped.
      if (int'(waddr) < DEPTH) bank_d[waddr] = wdata;
      ptr_d      = wrap_idx(int'(grant_idx), 1);
      grant_id_d = grant_idx;
      if (wr_count_q != 8'hFF) wr_count_d = wr_count_q + 8'd1;
    end
  end

  // Reads sample the pre-write bank, giving read-before-write.
  always_comb begin
    rd_data_d = '0;
    if (int'(rd_addr) < DEPTH) rd_data_d = bank_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
      rd_data_q  <= '0;
      grant_id_q <= '0;
      wr_count_q <= '0;
      ptr_q      <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= bank_d[i];
      rd_data_q  <= rd_data_d;
      grant_id_q <= grant_id_d;
      wr_count_q <= wr_count_d;
      ptr_q      <= ptr_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign grant_id = grant_id_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter.
// Covers reset, single grant, round-robin, wrap, collision, saturation.
module tb_reg_bank_arbiter;

  logic       clk;
  logic       rest;
  logic [3:0] req_valid;
  logic [7:0] req_addr;
  logic [15:0] req_data;
  logic [3:0] req_ready;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;
  logic [1:0] grant_id;
  logic [7:0] wr_count;

  int n_cmp;
  int n_err;

  reg_bank_arbiter dut (
    .clk       (clk),
    .rest      (rest),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .grant_id  (grant_id),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] a,
                         input logic [3:0] d);
    req_addr[i*2 +: 2] = a;
    req_data[i*4 +: 4] = d;
  endtask

  task automatic test_reset();
    rest = 1'b1;
    req_valid = 4'b1111;
    step();
    step();
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_ready got=%b exp=0000", req_ready);
    end
    n_cmp++;
    if (rd_data !== 4'h0 || wr_count !== 8'd0 || grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL rst_regs rd=%h cnt=%0d gid=%0d exp=0/0/0",
               rd_data, wr_count, grant_id);
    end
    rest = 1'b0;
    req_valid = 4'b0000;
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      step();
      n_cmp++;
      if (rd_data !== 4'h0) begin
        n_err++;
        $display("FAIL rst_bank%0d got=%h exp=0", a, rd_data);
      end
    end
  endtask

  task automatic test_single();
    set_req(2, 2'd2, 4'b1010);
    req_valid = 4'b0100;
    rd_addr = 2'd2;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL single_ready got=%b exp=0100", req_ready);
    end
    step();
    req_valid = 4'b0000;
    n_cmp++;
    if (grant_id !== 2'd2 || wr_count !== 8'd1) begin
      n_err++;
      $display("FAIL single_commit gid=%0d cnt=%0d exp=2/1",
               grant_id, wr_count);
    end
    step();
    n_cmp++;
    if (rd_data !== 4'b1010) begin
      n_err++;
      $display("FAIL single_read got=%b exp=1010", rd_data);
    end
  endtask

  task automatic test_round_robin();
    rest = 1'b1;
    step();
    rest = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 4'(i + 5));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_cmp++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        n_err++;
        $display("FAIL rr_ready%0d got=%b exp=%b", k, req_ready,
                 4'(1 << (k % 4)));
      end
      step();
      n_cmp++;
      if (grant_id !== 2'(k % 4)) begin
        n_err++;
        $display("FAIL rr_gid%0d got=%0d exp=%0d", k, grant_id, k % 4);
      end
    end
    req_valid = 4'b0000;
    n_cmp++;
    if (wr_count !== 8'd8) begin
      n_err++;
      $display("FAIL rr_count got=%0d exp=8", wr_count);
    end
    rd_addr = 2'd3;
    step();
    n_cmp++;
    if (rd_data !== 4'd8) begin
      n_err++;
      $display("FAIL rr_bank3 got=%0d exp=8", rd_data);
    end
  endtask

  task automatic test_wrap();
    req_valid = 4'b0010;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL wrap_ready1 got=%b exp=0010", req_ready);
    end
    step();
    req_valid = 4'b1001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_err++;
      $display("FAIL wrap_ready2 got=%b exp=1000", req_ready);
    end
    step();
    req_valid = 4'b0000;
    n_cmp++;
    if (grant_id !== 2'd3 || wr_count !== 8'd10) begin
      n_err++;
      $display("FAIL wrap_commit gid=%0d cnt=%0d exp=3/10",
               grant_id, wr_count);
    end
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL idle_ready got=%b exp=0000", req_ready);
    end
    step();
    n_cmp++;
    if (grant_id !== 2'd3 || wr_count !== 8'd10) begin
      n_err++;
      $display("FAIL idle_hold gid=%0d cnt=%0d exp=3/10",
               grant_id, wr_count);
    end
  endtask

  task automatic test_collision();
    rd_addr = 2'd0;
    set_req(0, 2'd1, 4'b0011);
    req_valid = 4'b0001;
    step();
    set_req(0, 2'd1, 4'b1100);
    rd_addr = 2'd1;
    step();
    req_valid = 4'b0000;
    n_cmp++;
    if (rd_data !== 4'b0011) begin
      n_err++;
      $display("FAIL coll_old got=%b exp=0011", rd_data);
    end
    step();
    n_cmp++;
    if (rd_data !== 4'b1100) begin
      n_err++;
      $display("FAIL coll_new got=%b exp=1100", rd_data);
    end
  endtask

  task automatic test_same_addr();
    set_req(0, 2'd3, 4'h1);
    set_req(2, 2'd3, 4'h2);
    req_valid = 4'b0101;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL same_ready got=%b exp=0100", req_ready);
    end
    step();
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    rd_addr = 2'd3;
    step();
    n_cmp++;
    if (rd_data !== 4'h1 || wr_count !== 8'd14) begin
      n_err++;
      $display("FAIL same_last rd=%h cnt=%0d exp=1/14", rd_data, wr_count);
    end
  endtask

  task automatic test_saturate_reset();
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 4'hF);
    req_valid = 4'b1111;
    for (int k = 0; k < 300; k++) step();
    n_cmp++;
    if (wr_count !== 8'd255) begin
      n_err++;
      $display("FAIL sat_count got=%0d exp=255", wr_count);
    end
    rest = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_rst_ready got=%b exp=0000", req_ready);
    end
    step();
    n_cmp++;
    if (wr_count !== 8'd0 || grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL mid_rst_regs cnt=%0d gid=%0d exp=0/0",
               wr_count, grant_id);
    end
    rest = 1'b0;
    req_valid = 4'b0000;
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      step();
      n_cmp++;
      if (rd_data !== 4'h0) begin
        n_err++;
        $display("FAIL mid_rst_bank%0d got=%h exp=0", a, rd_data);
      end
    end
    req_valid = 4'b1111;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL mid_rst_ptr got=%b exp=0001", req_ready);
    end
    req_valid = 4'b0000;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rest = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    rd_addr = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_collision();
    test_same_addr();
    test_saturate_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares a small bank of WIDTH-bit registers between NREQ write requesters.
- Round-robin arbitration; at most one write is committed per clock.
- One registered read port lets downstream logic observe any register.
- Acts as the sequencing and sharing controller in front of the team's 4-bit storage registers.

Parameters:
NREQ, 4, number of write requesters (2..8)
WIDTH, 4, data width of each storage register
DEPTH, 4, number of storage registers in the bank
ADDR_W, 2, address width; equals clog2(DEPTH)

Ports:
clk  input  1  system clock; all state updates on rising edge
rest  input  1  synchronous active-high reset
req_valid  input  NREQ  per-requester write request
req_addr  input  NREQ*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W]
req_data  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
req_ready  output  NREQ  one-hot grant; write of requester i accepted when req_valid[i] & req_ready[i]
rd_addr  input  ADDR_W  read address
rd_data  output  WIDTH  registered read data
grant_id  output  clog2(NREQ)  index of last granted requester (registered)
wr_count  output  8  saturating count of committed writes

Behaviour:
- Reset: rest is sampled on the rising clk edge. While rest=1:
  - every bank register, rd_data, grant_id, wr_count and the RR pointer go to 0.
  - req_ready is forced all-zero combinationally, so no write is accepted in a reset cycle.
- Reset mid-operation: a request pending when rest rises is dropped. The requester must keep req_valid asserted to be re-arbitrated after reset.
- Arbitration is combinational from req_valid and the RR pointer:
  - search starts at index ptr, wraps modulo NREQ; the first asserted req_valid wins.
  - req_ready is one-hot for the winner, all-zero if no request.
  - req_ready never asserts for a requester whose req_valid=0.
- Commit on a clock edge with a handshake (winner i, rest=0):
  - bank[req_addr_i] <= req_data_i.
  - ptr <= (i+1) mod NREQ.
  - grant_id <= i.
  - wr_count <= min(wr_count+1, 255).
- No handshake: ptr, grant_id and wr_count hold.
- Losers: keep req_valid, addr and data stable until they are granted.
- Fairness: with all NREQ requesting continuously, each is granted exactly once per NREQ cycles; grant order is ptr, ptr+1, ... with wrap.
- Read: rd_data <= bank[rd_addr] every cycle, 1-cycle latency.
- Read/write collision: same address in the same cycle returns the OLD value (read-before-write). The new value is visible on rd_data one cycle later if rd_addr is held.
- Only one write per cycle, so two requesters targeting the same address are serialized in RR order; the last granted value remains.
- Out-of-range address (DEPTH < 2^ADDR_W): the write is accepted but discarded; a read returns 0.
- wr_count saturates at 255 and does not wrap.

Test Plan:
- Reset: rest=1 for 2 cycles with req_valid=4'b1111 -> req_ready=0, rd_data=0, wr_count=0, grant_id=0; after release, bank reads 0 at all addresses.
- Single requester: req_valid=4'b0100, addr=2, data=4'b1010 -> req_ready=4'b0100 same cycle; after edge grant_id=2, wr_count=1; rd_addr=2 gives rd_data=4'b1010 one cycle later.
- Round-robin fairness: req_valid=4'b1111 held 8 cycles from reset -> grant sequence 0,1,2,3,0,1,2,3; wr_count=8.
- Pointer wrap/skip: after grant to 3, req_valid=4'b0010 -> requester 1 granted; then req_valid=4'b1001 -> requester 3 granted before 0 (ptr=2).
- Collision: bank[1]=4'b0011, write 4'b1100 to addr 1 with rd_addr=1 -> next cycle rd_data=4'b0011, following cycle 4'b1100.
- Reset mid-burst plus saturation:
  - 300 continuous writes -> wr_count stops at 255.
  - assert rest mid-stream -> wr_count=0, bank cleared, ptr restarts at 0.
